// File: rtl/jsv_pkg.sv
// Shared fractal-display constants and the bitmap reader state encoding.
package jsv_pkg;

  localparam int H_PIXELS_DEFAULT = 640;
  localparam int V_PIXELS_DEFAULT = 480;
  localparam int BITMAP_ADDR_W    = 23;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    REQ,
    DRAIN,
    DONE
  } bitmap_reader_state_t;

endpackage

// File: rtl/bitmap_fifo.sv
// Show-ahead 8-bit FIFO with flush; head visible combinationally from registered storage, 0 when empty.
// Push when full and pop when empty are ignored; flush overrides push and pop.
module bitmap_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        push,
  input  logic [7:0]                  din,
  input  logic                        pop,
  output logic [7:0]                  dout,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        empty,
  output logic                        full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bitmap_reader.sv
// Raster-order SDRAM pixel prefetcher feeding the VGA colour stage; one read in flight, GRAB one cycle after issue.
// Issues only with FIFO room and the writer off the bridge; BITMAP_READER_STATS_EN adds UNDERFLOW_CNT.
module bitmap_reader
  import jsv_pkg::*;
#(
  parameter int                H_PIXELS   = H_PIXELS_DEFAULT,
  parameter int                V_PIXELS   = V_PIXELS_DEFAULT,
  parameter int                FIFO_DEPTH = 16,
  parameter int                ADDR_W     = BITMAP_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              FRAME_START,
  input  logic              WR_BUSY,
  input  logic              PIX_POP,
  output logic [7:0]        PIX_DATA,
  output logic              PIX_VALID,
  output logic [ADDR_W-1:0] SDRAM_ADDR,
  output logic              SDRAM_GRAB,
  input  logic              SDRAM_ACK,
  input  logic [7:0]        BITMAP_INTENSITY,
  output logic              FRAME_DONE,
`ifdef BITMAP_READER_STATS_EN
  output logic [15:0]       UNDERFLOW_CNT,
  output logic              UNDERFLOW
`else
  output logic              UNDERFLOW
`endif
);

  localparam int TOTAL = H_PIXELS * V_PIXELS;
  localparam int PW    = $clog2(TOTAL + 1);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  bitmap_reader_state_t state_q, state_d;

  logic [PW-1:0] pix_cnt;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          unused_full;
  logic          fifo_push;
  logic          issue;

  assign unused_full = fifo_full;
  assign PIX_VALID   = !fifo_empty;

  bitmap_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .rst_n(RESET_N),
    .flush(FRAME_START),
    .push (fifo_push),
    .din  (BITMAP_INTENSITY),
    .pop  (PIX_POP),
    .dout (PIX_DATA),
    .count(fifo_count),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  always_comb begin
    state_d   = state_q;
    fifo_push = 1'b0;
    issue     = 1'b0;
    unique case (state_q)
      IDLE, DONE: if (FRAME_START) state_d = FETCH;
      FETCH: begin
        if (!FRAME_START && (fifo_count < CW'(FIFO_DEPTH)) && !WR_BUSY) begin
          state_d = REQ;
          issue   = 1'b1;
        end
      end
      REQ: begin
        // A new frame orphans the outstanding read; it is still completed, then dropped.
        if (FRAME_START) begin
          state_d = SDRAM_ACK ? FETCH : DRAIN;
        end else if (SDRAM_ACK) begin
          fifo_push = 1'b1;
          state_d   = (pix_cnt == PW'(TOTAL - 1)) ? DONE : FETCH;
        end
      end
      DRAIN: if (SDRAM_ACK) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      pix_cnt    <= '0;
      SDRAM_ADDR <= BASE_ADDR;
      SDRAM_GRAB <= 1'b0;
      FRAME_DONE <= 1'b0;
      UNDERFLOW  <= 1'b0;
    end else begin
      state_q    <= state_d;
      SDRAM_GRAB <= (state_d == REQ) || (state_d == DRAIN);
      FRAME_DONE <= (state_d == DONE);
      // Address is latched at issue so it stays put through a drain.
      if (issue) SDRAM_ADDR <= BASE_ADDR + ADDR_W'(pix_cnt);
      if (FRAME_START)    pix_cnt <= '0;
      else if (fifo_push) pix_cnt <= pix_cnt + 1'b1;
      if (FRAME_START)                UNDERFLOW <= 1'b0;
      else if (PIX_POP && fifo_empty) UNDERFLOW <= 1'b1;
    end
  end

`ifdef BITMAP_READER_STATS_EN
  always_ff @(posedge CLK) begin
    if (!RESET_N || FRAME_START) begin
      UNDERFLOW_CNT <= '0;
    end else if (PIX_POP && fifo_empty && (UNDERFLOW_CNT != 16'hFFFF)) begin
      UNDERFLOW_CNT <= UNDERFLOW_CNT + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bitmap_reader.sv
// Randomized bench for bitmap_reader against a queue-based FIFO/bridge model on a reduced 40x32 frame.
module tb_bitmap_reader;

  localparam int H = 40;
  localparam int V = 32;
  localparam int TOTAL = H * V;
  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RESET_N, FRAME_START, WR_BUSY, PIX_POP, SDRAM_ACK;
  logic [7:0]  BITMAP_INTENSITY, PIX_DATA;
  logic        PIX_VALID, SDRAM_GRAB, FRAME_DONE, UNDERFLOW;
  logic [22:0] SDRAM_ADDR;
`ifdef BITMAP_READER_STATS_EN
  logic [15:0] UNDERFLOW_CNT;
`endif

  bitmap_reader #(
    .H_PIXELS(H), .V_PIXELS(V), .FIFO_DEPTH(DEPTH), .ADDR_W(23), .BASE_ADDR(23'd0)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FRAME_START(FRAME_START), .WR_BUSY(WR_BUSY),
    .PIX_POP(PIX_POP), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
    .SDRAM_ADDR(SDRAM_ADDR), .SDRAM_GRAB(SDRAM_GRAB), .SDRAM_ACK(SDRAM_ACK),
    .BITMAP_INTENSITY(BITMAP_INTENSITY), .FRAME_DONE(FRAME_DONE),
`ifdef BITMAP_READER_STATS_EN
    .UNDERFLOW_CNT(UNDERFLOW_CNT),
`endif
    .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  // stimulus knobs
  bit rst_req = 0, fs_req = 0, busy = 0, pop_all = 0, pop_rand = 0, force_pop = 0;
  int lat = 1;

  // reference model state
  logic [7:0]  q[$];
  int          pushed = 0, popped = 0, ufc = 0, wait_cnt = 0;
  bit          uf = 0, discard = 0, started = 0, was_reset = 0;
  bit          busy_dec = 0, grab_prev = 0, grab_rose = 0;
  int          size_dec = 0;
  logic [22:0] addr_prev = '0;
  int          reads_issued = 0, cyc = 0, ack_cyc = 0;
  int          n_checks = 0, n_fail = 0;

  function automatic logic [7:0] pix_of(input logic [22:0] a);
    logic [31:0] t;
    t = {9'd0, a} * 32'd2654435761;
    return t[31:24] ^ a[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic       do_pop, ack;
    logic [7:0] head;
    do_pop = force_pop || (pop_all && PIX_VALID === 1'b1) ||
             (pop_rand && $urandom_range(0, 2) == 0);
    ack = 1'b0;
    if (SDRAM_GRAB === 1'b1) begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        ack = 1'b1;
        wait_cnt = 0;
      end
    end else begin
      wait_cnt = 0;
    end
    RESET_N          = !rst_req;
    FRAME_START      = fs_req;
    WR_BUSY          = busy;
    PIX_POP          = do_pop;
    SDRAM_ACK        = ack;
    BITMAP_INTENSITY = ack ? pix_of(SDRAM_ADDR) : 8'($urandom);
    if (ack) ack_cyc = cyc + 1;

    // what the DUT should hold after this edge
    busy_dec  = busy;
    size_dec  = q.size();
    was_reset = rst_req;
    if (rst_req) begin
      q.delete();
      pushed = 0; uf = 0; ufc = 0; discard = 0; started = 0;
    end else begin
      if (fs_req) begin
        q.delete();
        pushed = 0; uf = 0; ufc = 0; started = 1;
        if (SDRAM_GRAB === 1'b1) discard = 1;
      end else if (do_pop) begin
        if (q.size() == 0) begin
          uf = 1;
          if (ufc != 16'hFFFF) ufc++;
        end else begin
          void'(q.pop_front());
          popped++;
        end
      end
      if (ack) begin
        if (discard) discard = 0;
        else begin
          q.push_back(pix_of(SDRAM_ADDR));
          pushed++;
        end
      end
    end

    @(posedge CLK);
    #1;
    cyc++;

    head = 8'h00;
    if (q.size() != 0) head = q[0];
    check("pix_valid", PIX_VALID, q.size() != 0);
    check("pix_data", PIX_DATA, head);
    check("underflow", UNDERFLOW, uf);
    check("frame_done", FRAME_DONE, pushed == TOTAL);
`ifdef BITMAP_READER_STATS_EN
    check("underflow_cnt", UNDERFLOW_CNT, ufc);
`endif
    if (was_reset) begin
      check("reset_grab", SDRAM_GRAB, 0);
      check("reset_addr", SDRAM_ADDR, 0);
    end
    grab_rose = (SDRAM_GRAB === 1'b1) && !grab_prev;
    if (grab_rose) begin
      reads_issued++;
      check("grab_after_start", started, 1);
      check("grab_addr", SDRAM_ADDR, pushed);
      check("grab_busy", busy_dec, 0);
      check("grab_space", size_dec < DEPTH, 1);
    end else if (SDRAM_GRAB === 1'b1) begin
      check("grab_hold_addr", SDRAM_ADDR, addr_prev);
    end
    grab_prev = (SDRAM_GRAB === 1'b1);
    addr_prev = SDRAM_ADDR;
  endtask

  initial begin
    int r0, p0, n, fs_cyc;

    // reset and idle outputs
    rst_req = 1;
    repeat (3) tick();
    rst_req = 0;
    tick();
    check("idle_grab", SDRAM_GRAB, 0);
    check("idle_addr", SDRAM_ADDR, 0);
    check("idle_valid", PIX_VALID, 0);

    // prefetch fills exactly DEPTH entries with no consumer
    lat = 1;
    r0 = reads_issued;
    fs_req = 1; tick(); fs_req = 0;
    repeat (80) tick();
    check("fill_reads", reads_issued - r0, DEPTH);
    check("fill_grab_idle", SDRAM_GRAB, 0);
    check("fill_valid", PIX_VALID, 1);
    check("fill_head", PIX_DATA, pix_of(23'd0));

    // full frame, eager consumer, latency 3
    lat = 3; pop_all = 1;
    r0 = reads_issued; p0 = popped;
    fs_req = 1; tick(); fs_req = 0;
    n = 0;
    while (FRAME_DONE !== 1'b1 && n < 20000) begin tick(); n++; end
    check("frame_done_reached", FRAME_DONE, 1);
    check("frame_reads", reads_issued - r0, TOTAL);
    repeat (40) tick();
    check("frame_popped", popped - p0, TOTAL);
    check("frame_no_underflow", UNDERFLOW, 0);
    check("done_no_grab", SDRAM_GRAB, 0);

    // writer holds the bridge for 50 cycles mid-frame
    pop_all = 0; lat = 1;
    fs_req = 1; tick(); fs_req = 0;
    n = 0;
    while (pushed < 5 && n < 500) begin tick(); n++; end
    check("busy_prefill", pushed, 5);
    busy = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("busy_no_grab", SDRAM_GRAB, 0);
    end
    busy = 0;
    n = 0;
    do begin tick(); n++; end while (!grab_rose && n < 100);
    check("busy_resume", grab_rose, 1);
    check("busy_resume_addr", SDRAM_ADDR, 5);

    // new frame while a read at address 1000 is outstanding
    pop_all = 1;
    fs_req = 1; tick(); fs_req = 0;
    n = 0;
    while (!(grab_rose && SDRAM_ADDR == 23'd1000) && n < 8000) begin tick(); n++; end
    check("drain_reach_1000", SDRAM_ADDR, 1000);
    lat = 5;
    fs_req = 1; fs_cyc = cyc + 1; tick(); fs_req = 0;
    n = 0;
    while (SDRAM_GRAB === 1'b1 && n < 20) begin tick(); n++; end
    check("drain_grab_until_ack", cyc, ack_cyc);
    check("drain_ack_delay", ack_cyc - fs_cyc, 4);
    check("drain_discarded", PIX_VALID, 0);
    lat = 1;
    n = 0;
    do begin tick(); n++; end while (!grab_rose && n < 100);
    check("drain_next_grab", grab_rose, 1);
    check("drain_next_addr", SDRAM_ADDR, 0);

    // pop on empty FIFO
    pop_all = 0; busy = 1;
    n = 0;
    while (SDRAM_GRAB === 1'b1 && n < 20) begin tick(); n++; end
    fs_req = 1; tick(); fs_req = 0;
    tick();
    force_pop = 1; tick(); force_pop = 0;
    check("uf_flag", UNDERFLOW, 1);
    check("uf_data", PIX_DATA, 0);
`ifdef BITMAP_READER_STATS_EN
    check("uf_cnt_one", UNDERFLOW_CNT, 1);
`endif
    force_pop = 1; fs_req = 1; tick(); force_pop = 0; fs_req = 0;
    check("uf_cleared", UNDERFLOW, 0);
    busy = 0;

    // random traffic with occasional frame restarts
    pop_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) busy = !busy;
      if ($urandom_range(0, 19) == 0) lat = $urandom_range(1, 4);
      fs_req = ($urandom_range(0, 299) == 0);
      tick();
    end
    pop_rand = 0; fs_req = 0; busy = 0; lat = 3;

    // reset in the middle of a read
    fs_req = 1; tick(); fs_req = 0;
    n = 0;
    do begin tick(); n++; end while (SDRAM_GRAB !== 1'b1 && n < 100);
    check("rst_req_active", SDRAM_GRAB, 1);
    rst_req = 1; tick(); rst_req = 0;
    check("rst_mid_valid", PIX_VALID, 0);
    check("rst_mid_done", FRAME_DONE, 0);
    r0 = reads_issued;
    repeat (20) tick();
    check("rst_stays_idle", reads_issued - r0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
